// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register between two CPU stages.
// Carries a control bundle and a data bundle with a valid/ready handshake.
// It also supports a synchronous flush and an optional skid entry.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   upstream offers a beat
//   in_ready   stage accepts this cycle (registered when SKID=1)
//   in_ctrl    control bundle in (CTRL_W)
//   in_data    data bundle in (DATA_W)
//   flush      kill every held entry and any beat offered this cycle
//   out_valid  main entry holds a valid beat
//   out_ready  downstream consumes the main entry
//   out_ctrl   held control; forced to zero whenever out_valid=0
//   out_data   held data; only reset clears it
//   occupancy  number of entries held (0..2)
module pipe_stage_reg #(
   parameter int CTRL_W = 24,
   parameter int DATA_W = 128,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              acc, pop;
   logic              ld_m_in, ld_m_s, ld_s_in;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl;
   logic [DATA_W-1:0] m_data, s_data;

   assign out_valid = (state_q != EMPTY);
   assign out_ctrl  = m_ctrl;
   assign out_data  = m_data;
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   generate
      if (SKID != 0) begin : g_skid
         // in_ready comes from a flop here, so out_ready has no
         // combinational path to in_ready. The flop is high iff the
         // skid entry will be free next cycle.
         logic rdy_q;
         always_ff @(posedge clk) begin
            if (rst) rdy_q <= 1'b1;
            else     rdy_q <= (state_d != FULL);
         end
         assign in_ready = rdy_q;
      end else begin : g_flat
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      ld_m_in = 1'b0;
      ld_m_s  = 1'b0;
      ld_s_in = 1'b0;
      if (flush) begin
         // Flush wins over accept and pop. The offered beat is dropped.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (acc) begin
               state_d = ONE;
               ld_m_in = 1'b1;
            end
            ONE: begin
               if (acc && pop) begin
                  ld_m_in = 1'b1;
               end else if (acc && (SKID != 0)) begin
                  // Main entry is stalled. The younger beat parks in skid.
                  state_d = FULL;
                  ld_s_in = 1'b1;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: if (pop) begin
               state_d = ONE;
               ld_m_s  = 1'b1;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         m_ctrl  <= '0;
         m_data  <= '0;
         s_ctrl  <= '0;
         s_data  <= '0;
      end else begin
         state_q <= state_d;
         if (ld_m_in) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
         end else if (ld_m_s) begin
            m_ctrl <= s_ctrl;
            m_data <= s_data;
         end else if (state_d == EMPTY) begin
            // When the stage goes empty it shows a bubble on ctrl.
            // The data bundle keeps its last value.
            m_ctrl <= '0;
         end
         if (ld_s_in) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
         end
      end
   end

   always_comb begin
      case (state_q)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [23:0]  c;
      logic [127:0] d;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst, in_valid, flush, out_ready;
   logic [23:0]  in_ctrl;
   logic [127:0] in_data;

   logic         rdy1, vld1, rdy0, vld0;
   logic [23:0]  ctrl1, ctrl0;
   logic [127:0] data1, data0;
   logic [1:0]   occ1, occ0;

   int vectors = 0;
   int errs    = 0;

   ent_t         q1[$], q0[$];
   logic [127:0] hold1, hold0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(24), .DATA_W(128), .SKID(1)) u_skid (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(vld1), .out_ready(out_ready), .out_ctrl(ctrl1),
      .out_data(data1), .occupancy(occ1));

   pipe_stage_reg #(.CTRL_W(24), .DATA_W(128), .SKID(0)) u_flat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(vld0), .out_ready(out_ready), .out_ctrl(ctrl0),
      .out_data(data0), .occupancy(occ0));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (flat).
   task automatic cyc();
      logic a1, a0, p1, p0, e1, e0;
      ent_t e;
      @(negedge clk);
      e1 = (q1.size() < 2);
      e0 = (q0.size() == 0) || out_ready;
      chk("skid.in_ready",  rdy1,  e1);
      chk("skid.out_valid", vld1,  q1.size() != 0);
      chk("skid.out_ctrl",  ctrl1, (q1.size() != 0) ? q1[0].c : 24'h0);
      chk("skid.out_data",  data1, (q1.size() != 0) ? q1[0].d : hold1);
      chk("skid.occupancy", occ1,  q1.size());
      chk("flat.in_ready",  rdy0,  e0);
      chk("flat.out_valid", vld0,  q0.size() != 0);
      chk("flat.out_ctrl",  ctrl0, (q0.size() != 0) ? q0[0].c : 24'h0);
      chk("flat.out_data",  data0, (q0.size() != 0) ? q0[0].d : hold0);
      chk("flat.occupancy", occ0,  q0.size());
      a1 = in_valid && e1;
      a0 = in_valid && e0;
      p1 = (q1.size() != 0) && out_ready;
      p0 = (q0.size() != 0) && out_ready;
      e.c = in_ctrl;
      e.d = in_data;
      @(posedge clk);
      if (rst) begin
         q1.delete(); q0.delete();
         hold1 = '0; hold0 = '0;
      end else begin
         if (q1.size() != 0) hold1 = q1[0].d;
         if (q0.size() != 0) hold0 = q0[0].d;
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (p1) void'(q1.pop_front());
            if (p0) void'(q0.pop_front());
            if (a1) q1.push_back(e);
            if (a0) q0.push_back(e);
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [23:0] c, input logic ordy);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = rnd128();
      out_ready = ordy;
   endtask

   initial begin
      // Reset held two cycles while garbage is offered upstream.
      rst = 1'b1; flush = 1'b0;
      drive(1'b1, 24'hFFFFFF, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      q1.delete(); q0.delete();
      hold1 = '0; hold0 = '0;
      rst = 1'b0;
      drive(1'b0, 24'h0, 1'b1);
      cyc();

      // Back-to-back streaming.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 24'(i), 1'b1);
         cyc();
      end
      drive(1'b0, 24'h0, 1'b1);
      cyc(); cyc();

      // Stall with A, B, C: B lands in skid and C waits upstream.
      drive(1'b1, 24'h00000A, 1'b1); cyc();
      drive(1'b1, 24'h00000B, 1'b0); cyc();
      drive(1'b1, 24'h00000C, 1'b0); cyc(); cyc();
      // The flat stage is stalled too. Its outputs must hold for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         cyc();
      end
      out_ready = 1'b1; cyc(); cyc();
      drive(1'b0, 24'h0, 1'b1);
      repeat (3) cyc();

      // Flush while full. D is offered in the flush cycle and must vanish.
      drive(1'b1, 24'h000011, 1'b1); cyc();
      drive(1'b1, 24'h000012, 1'b0); cyc();
      drive(1'b1, 24'h00000D, 1'b0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, 24'h0, 1'b0);
      cyc(); cyc();

      // ONE state with accept and pop on the same edge.
      drive(1'b1, 24'h000021, 1'b1); cyc();
      drive(1'b1, 24'h000022, 1'b1); cyc();
      drive(1'b1, 24'h000023, 1'b1); cyc();
      // Reset and flush together give the reset values.
      drive(1'b1, 24'h000024, 1'b1);
      rst = 1'b1; flush = 1'b1;
      cyc();
      rst = 1'b0; flush = 1'b0;
      drive(1'b0, 24'h0, 1'b1);
      cyc();

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), 24'($urandom), ($urandom_range(0, 2) != 0));
         flush = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         cyc();
      end
      rst = 1'b0; flush = 1'b0;
      drive(1'b0, 24'h0, 1'b1);
      cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register, the generic successor of the fixed ID/EX latch: it carries one control bundle and one data bundle between two pipeline stages with a valid/ready handshake, synchronous flush, and an optional skid slot. It is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined CPU. Flushes zero the control bundle so killed instructions become bubbles.

## Interface
- CTRL_W, 24: control bundle width (RegWr, MemWr, Branch, …); zeroed on flush/empty.
- DATA_W, 128: data bundle width (busA, busB, PC, imm, regs…); never zeroed except at reset.
- SKID, 1: 0 = single register, in_ready combinational; 1 = adds one skid entry, in_ready registered.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle; transfer when in_valid && in_ready.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data bundle.
- flush  in  1  kill all held entries and any input this cycle.
- out_valid  out  1  main register holds a valid instruction.
- out_ready  in  1  downstream consumes; transfer when out_valid && out_ready (out_ready=0 is a stall).
- out_ctrl  out  CTRL_W  held control; all-zero whenever out_valid=0.
- out_data  out  DATA_W  held data.
- occupancy  out  2  entries held: 0, 1, or 2 (2 only when SKID=1).

## Operation
- Storage: main entry M (drives outputs); skid entry S exists only if SKID=1.
- States (SKID=1): EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid). SKID=0: EMPTY, ONE.
- in_ready: SKID=0 → !out_valid || out_ready. SKID=1 → register, 1 iff S empty.
- Transitions SKID=1 (acc = in accept, pop = out transfer):
  - EMPTY: acc → ONE (M ← in).
  - ONE: acc&pop → ONE (M ← in); acc&!pop → FULL (S ← in); !acc&pop → EMPTY.
  - FULL: pop → ONE (M ← S); no accept possible (in_ready=0).
- SKID=0: M ← in on accept; otherwise M valid clears on pop; holds on stall.
- Order preserved: S always younger than M.
- Flush: next state EMPTY; M/S valid ← 0, out_ctrl ← 0, out_data holds; input presented in the flush cycle is discarded even if in_ready=1. Flush beats accept and pop. Upstream sees no handshake failure; it treats the dropped beat as consumed.
- Empty contract: out_valid=0 ⇒ out_ctrl=0 so downstream sees a bubble with RegWr=MemWr=Branch=0.
- occupancy = M.valid + S.valid.

## Timing
- Reset (rst=1 at edge): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 from the cycle after reset edge (SKID=1 register resets to 1); S cleared. rst overrides flush and handshakes.
- Latency: accepted beat appears on outputs the next cycle (1 cycle) when M empty or popped; via skid, 1 cycle after the pop that frees M.
- Throughput: 1 beat/cycle with out_ready=1, both modes.
- SKID=1: after out_ready drops with M valid, one further beat is accepted into S; in_ready falls the following cycle; rises the cycle after first pop from FULL.
- No combinational path out_ready → in_ready when SKID=1.
- Flush mid-stall: outputs invalid next cycle, in_ready=1 next cycle.
- Reset mid-operation: all held beats lost, same values as power-up reset.

## Test plan
- Reset: rst=1 two cycles with in_valid=1, in_ctrl=0xFFFFFF → out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 after release.
- Streaming: out_ready=1, push ctrl 0x000001..0x000008 back-to-back → same sequence on out_ctrl, one cycle later each, no gaps, occupancy=1.
- Stall/skid (SKID=1): push A,B,C; out_ready=0 after A captured → B in S, in_ready=0, occupancy=2, C held upstream; out_ready=1 → out A, B, C in order, no loss/duplicate.
- Stall (SKID=0): out_ready=0 with M valid → in_ready=0 same cycle, out_ctrl/out_data stable for 5 cycles.
- Flush: FULL state, flush=1 with in_valid=1 (D) → next cycle out_valid=0, out_ctrl=0, occupancy=0, D never appears; out_data unchanged.
- Simultaneous: ONE state, in_valid=1, out_ready=1, flush=0 → M replaced same edge, occupancy stays 1; repeat with rst=1 and flush=1 together → reset values.
